// File: rtl/hyperbus_delay_line_ctrl.sv
// Programmable delay line for the HyperBus RWDS/clock path. The controller walks the
// tap select one step at a time, and only inside PHY quiescent windows.
`timescale 1ps/1ps
module hyperbus_delay_line_ctrl #(
    parameter int unsigned NUM_TAPS      = 8,
    parameter int unsigned STEP_INTERVAL = 4,
    parameter int unsigned RESET_TAP     = 0,
    parameter int unsigned TAP_DELAY_PS  = 250
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [31:0]                 delay_i,
    input  logic                        delay_valid_i,
    output logic                        delay_ready_o,
    input  logic                        idle_i,
    input  logic                        in_i,
    output logic                        out_o,
    output logic [$clog2(NUM_TAPS)-1:0] tap_sel_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        clipped_o
);

    localparam int unsigned TAP_W = $clog2(NUM_TAPS);
    localparam int unsigned CNT_W = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEP_INTERVAL - 1);
    localparam logic [TAP_W-1:0] MAX_TAP  = TAP_W'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_IDLE,
        HOLD,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [TAP_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clipped_q, clipped_d;

    logic             req_clip;
    logic [TAP_W-1:0] req_target;

    // Full-width compare so large codes saturate instead of wrapping.
    assign req_clip   = (delay_i > 32'(NUM_TAPS - 1));
    assign req_target = req_clip ? MAX_TAP : TAP_W'(delay_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            tap_q     <= TAP_W'(RESET_TAP);
            target_q  <= TAP_W'(RESET_TAP);
            cnt_q     <= '0;
            clipped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            clipped_q <= clipped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        clipped_d = clipped_q;
        case (state_q)
            IDLE: begin
                if (delay_valid_i) begin
                    target_d  = req_target;
                    clipped_d = req_clip;
                    state_d   = (req_target == tap_q) ? DONE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (idle_i) begin
                    tap_d   = (target_q > tap_q) ? tap_q + 1'b1 : tap_q - 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = (tap_q == target_q) ? DONE : WAIT_IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign tap_sel_o     = tap_q;
    assign delay_ready_o = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign clipped_o     = clipped_q;

`ifdef SYNTHESIS
    // chain[k+1] is tap k: the output of buffer k, after k+1 cells.
    logic [NUM_TAPS:0]   chain;
    logic [NUM_TAPS-1:0] lvl [TAP_W+1];

    assign chain[0] = in_i;
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_chain
        tc_clk_buffer i_buf (
            .clk_i (chain[k]),
            .clk_o (chain[k+1])
        );
    end

    assign lvl[0] = chain[NUM_TAPS:1];
    for (genvar l = 0; l < TAP_W; l++) begin : g_level
        for (genvar j = 0; j < (NUM_TAPS >> (l + 1)); j++) begin : g_mux
            tc_clk_mux2 i_mux (
                .clk0_i    (lvl[l][2*j]),
                .clk1_i    (lvl[l][2*j+1]),
                .clk_sel_i (tap_q[l]),
                .clk_o     (lvl[l+1][j])
            );
        end
    end
    assign out_o = lvl[TAP_W][0];
`else
    always @(in_i) begin
        out_o <= #((int'(tap_q) + 1) * int'(TAP_DELAY_PS)) in_i;
    end
`endif

endmodule
